// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// wait-state handling and an ACCESS-phase watchdog that forces an error completion.
module apb_master_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ack,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ack,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_grant;
   logic              arb_sel;
   logic              any_valid;
   logic              wd_hit;
   logic              complete;
   logic              start;
   logic [WD_W-1:0]   wd_cnt;
   logic [DATA_W-1:0] res_data;
   logic              res_err;

   // last_grant doubles as the owner of the transfer currently on the bus.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      arb_sel   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      wd_hit    = (TIMEOUT != 0) && !pready && (wd_cnt == WD_W'(TIMEOUT - 1));
      complete  = (state == ACCESS) && (pready || wd_hit);
      start     = any_valid && ((state == IDLE) || complete);
      res_data  = (wd_hit || pwrite) ? '0 : prdata;
      res_err   = wd_hit | pslverr;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_valid) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (complete) state_nxt = any_valid ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      psel     = (state != IDLE);
      penable  = (state == ACCESS);
      req0_ack = (state == SETUP) && !last_grant;
      req1_ack = (state == SETUP) && last_grant;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         paddr      <= '0;
         pwdata     <= '0;
         pwrite     <= 1'b0;
      end else if (start) begin
         last_grant <= arb_sel;
         paddr      <= arb_sel ? req1_addr  : req0_addr;
         pwdata     <= arb_sel ? req1_wdata : req0_wdata;
         pwrite     <= arb_sel ? req1_write : req0_write;
      end
   end

   // Counts ACCESS cycles without pready; cleared while in SETUP.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                            wd_cnt <= '0;
      else if (state == SETUP)              wd_cnt <= '0;
      else if (state == ACCESS && !pready)  wd_cnt <= wd_cnt + WD_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
         req0_rdata <= '0;
         req1_rdata <= '0;
         req0_err   <= 1'b0;
         req1_err   <= 1'b0;
      end else begin
         req0_done <= complete && !last_grant;
         req1_done <= complete && last_grant;
         if (complete && !last_grant) begin
            req0_rdata <= res_data;
            req0_err   <= res_err;
         end
         if (complete && last_grant) begin
            req1_rdata <= res_data;
            req1_err   <= res_err;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter: behavioural requesters and slave,
// with a transaction/timeline reference model predicting every output each cycle.
module tb_apb_master_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          req0_valid, req0_write, req0_ack, req0_done, req0_err;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, req0_rdata;
   logic          req1_valid, req1_write, req1_ack, req1_done, req1_err;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, req1_rdata;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;
   logic          pwrite, psel, penable, pready, pslverr;

   apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
      .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
      .req1_rdata(req1_rdata), .req1_err(req1_err),
      .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct {
      int   waits;
      logic slverr;
   } rsp_t;

   txn_t q0[$];
   txn_t q1[$];
   rsp_t rq[$];

   int n_checks = 0;
   int n_fail   = 0;
   int c        = 0;

   // requester state
   logic vld [2];
   txn_t cur [2];
   int   gap [2];
   int   gap_max = 0;

   // slave state
   rsp_t cur_rsp;
   int   acc_cnt;

   // reference model: timeline of the transfer on the bus and the pending done
   logic          m_last, busy, own, m_tmo;
   txn_t          m_txn;
   int            next_arb, ack_cyc, sel_from, sel_to, en_from;
   int            done_cyc;
   logic          done_who, done_err;
   logic [DW-1:0] done_data;
   logic [AW-1:0] exp_paddr;
   logic [DW-1:0] exp_pwdata;
   logic          exp_pwrite;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, c);
      end
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      t.write = 1'($urandom);
      t.addr  = $urandom;
      t.wdata = $urandom;
      return t;
   endfunction

   function automatic txn_t mk_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.write = w;
      t.addr  = a;
      t.wdata = d;
      return t;
   endfunction

   task automatic push_rsp(input int w, input logic e);
      rsp_t r;
      r.waits  = w;
      r.slverr = e;
      rq.push_back(r);
   endtask

   task automatic model_reset();
      m_last     = 1'b1;
      busy       = 1'b0;
      own        = 1'b0;
      m_tmo      = 1'b0;
      m_txn      = '0;
      next_arb   = 0;
      ack_cyc    = -10;
      sel_from   = -10;
      sel_to     = -20;
      en_from    = -10;
      done_cyc   = -10;
      done_who   = 1'b0;
      done_err   = 1'b0;
      done_data  = '0;
      exp_paddr  = '0;
      exp_pwdata = '0;
      exp_pwrite = 1'b0;
      acc_cnt    = 0;
      cur_rsp.waits  = 0;
      cur_rsp.slverr = 1'b0;
      c = 0;
   endtask

   task automatic drive_reqs();
      req0_valid = vld[0]; req0_write = cur[0].write; req0_addr = cur[0].addr; req0_wdata = cur[0].wdata;
      req1_valid = vld[1]; req1_write = cur[1].write; req1_addr = cur[1].addr; req1_wdata = cur[1].wdata;
   endtask

   // One cycle: check outputs, then set requester/slave inputs, then advance the model.
   task automatic cycle_body();
      logic e_sel, e_en, win, ackr;
      int   len;
      e_sel = (c >= sel_from) && (c <= sel_to);
      e_en  = (c >= en_from) && (c <= sel_to);
      check("ack0", req0_ack, (c == ack_cyc) && !own);
      check("ack1", req1_ack, (c == ack_cyc) && own);
      check("psel", psel, e_sel);
      check("penable", penable, e_en);
      check("paddr", paddr, exp_paddr);
      check("pwdata", pwdata, exp_pwdata);
      check("pwrite", pwrite, exp_pwrite);
      check("done0", req0_done, (c == done_cyc) && !done_who);
      check("done1", req1_done, (c == done_cyc) && done_who);
      if (c == done_cyc) begin
         check("rdata", done_who ? req1_rdata : req0_rdata, done_data);
         check("err", done_who ? req1_err : req0_err, done_err);
      end

      for (int r = 0; r < 2; r++) begin
         ackr = (r == 0) ? req0_ack : req1_ack;
         if (ackr && vld[r]) vld[r] = 1'b0;
         if (!vld[r]) begin
            if (gap[r] > 0) gap[r]--;
            else if ((r == 0) ? (q0.size() != 0) : (q1.size() != 0)) begin
               cur[r] = (r == 0) ? q0.pop_front() : q1.pop_front();
               vld[r] = 1'b1;
               gap[r] = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            end
         end
      end
      drive_reqs();

      if (psel && penable) begin
         pready  = (acc_cnt >= cur_rsp.waits);
         pslverr = cur_rsp.slverr;
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         pready  = 1'($urandom);
         pslverr = 1'($urandom);
      end
      prdata = $urandom;

      if (c == next_arb) begin
         if (busy) begin
            done_cyc  = c + 1;
            done_who  = own;
            done_err  = m_tmo | pslverr;
            done_data = (m_tmo || m_txn.write) ? '0 : prdata;
            busy      = 1'b0;
         end
         if (vld[0] || vld[1]) begin
            win    = (vld[0] && vld[1]) ? !m_last : vld[1];
            m_last = win;
            own    = win;
            m_txn  = cur[win];
            exp_paddr  = m_txn.addr;
            exp_pwdata = m_txn.wdata;
            exp_pwrite = m_txn.write;
            if (rq.size() != 0) cur_rsp = rq.pop_front();
            else begin
               cur_rsp.waits  = $urandom_range(0, 6);
               cur_rsp.slverr = ($urandom_range(0, 3) == 0);
            end
            m_tmo    = (cur_rsp.waits >= T);
            len      = m_tmo ? T : cur_rsp.waits + 1;
            ack_cyc  = c + 1;
            sel_from = c + 1;
            en_from  = c + 2;
            sel_to   = c + 1 + len;
            next_arb = c + 1 + len;
            busy     = 1'b1;
         end else begin
            next_arb = c + 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      c++;
      cycle_body();
   endtask

   function automatic bit drained();
      return (q0.size() == 0) && (q1.size() == 0) && !vld[0] && !vld[1] && !busy && (c > done_cyc);
   endfunction

   task automatic run_phase(input string name, input int budget);
      int n;
      n = 0;
      while (!drained()) begin
         if (n >= budget) begin
            check({name, "_budget"}, 32'd0, 32'd1);
            return;
         end
         tick();
         n++;
      end
      repeat (2) tick();
   endtask

   task automatic clear_reqs();
      for (int r = 0; r < 2; r++) begin
         vld[r] = 1'b0;
         cur[r] = '0;
         gap[r] = 0;
      end
      drive_reqs();
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      clear_reqs();
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check("rst_psel", psel, 1'b0);
      check("rst_penable", penable, 1'b0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_pwrite", pwrite, 1'b0);
      check("rst_acks", {req1_ack, req0_ack}, 32'd0);
      check("rst_dones", {req1_done, req0_done}, 32'd0);
      check("rst_errs", {req1_err, req0_err}, 32'd0);
      check("rst_rdata0", req0_rdata, 32'd0);
      check("rst_rdata1", req1_rdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      cycle_body();

      // both requesters contend from reset, four back-to-back each
      for (int i = 0; i < 4; i++) begin
         q0.push_back(rand_txn());
         q1.push_back(rand_txn());
         push_rsp($urandom_range(0, 2), 1'b0);
         push_rsp($urandom_range(0, 2), 1'b0);
      end
      run_phase("backtoback", 200);

      q0.push_back(mk_txn(1'b0, 32'h10, 32'h0));
      push_rsp(0, 1'b0);
      run_phase("single_read", 40);

      q1.push_back(mk_txn(1'b1, 32'h20, 32'hA5A5A5A5));
      push_rsp(3, 1'b0);
      run_phase("write_waits", 40);

      // watchdog boundaries: well past, exactly at, and one short of TIMEOUT
      q0.push_back(mk_txn(1'b0, 32'h30, 32'h0));
      q0.push_back(mk_txn(1'b0, 32'h34, 32'h0));
      q0.push_back(mk_txn(1'b1, 32'h38, 32'h1234));
      push_rsp(9, 1'b0);
      push_rsp(T, 1'b0);
      push_rsp(T - 1, 1'b0);
      run_phase("watchdog", 80);

      q1.push_back(mk_txn(1'b0, 32'h40, 32'h0));
      push_rsp(1, 1'b1);
      run_phase("slverr_read", 40);

      gap_max = 3;
      for (int i = 0; i < 20; i++) begin
         q0.push_back(rand_txn());
         q1.push_back(rand_txn());
      end
      run_phase("random", 2000);
      gap_max = 0;

      // reset in the middle of an ACCESS phase
      q0.push_back(mk_txn(1'b0, 32'h50, 32'h0));
      push_rsp(6, 1'b0);
      for (int i = 0; i < 20 && !(psel && penable); i++) tick();
      check("reach_access", psel && penable, 1'b1);
      reset = 1'b1;
      #1;
      check("midrst_psel", psel, 1'b0);
      check("midrst_penable", penable, 1'b0);
      check("midrst_paddr", paddr, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         check("midrst_dones", {req1_done, req0_done}, 32'd0);
      end
      @(negedge clock);
      rq.delete();
      q0.delete();
      q1.delete();
      clear_reqs();
      model_reset();
      reset = 1'b0;
      q0.push_back(mk_txn(1'b0, 32'h60, 32'h0));
      push_rsp(0, 1'b0);
      cycle_body();
      run_phase("after_reset", 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-port APB master controller sitting between the bridge-side requesters and the shared APB slave bus. It arbitrates round-robin between two requesters, sequences the APB SETUP/ACCESS phases, honours slave wait states via `pready`, and returns read data and error status to the granted requester. A watchdog terminates stalled ACCESS phases with an error.

## Interface
Parameters:
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT`, 16, max ACCESS cycles with `pready`=0 before forced error completion; 0 disables the watchdog

Ports. One clock; reset is asynchronous and active-high. `reqN_*` exists for N=0 and N=1.
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `reqN_valid`  in  1  requester N has a transaction pending
- `reqN_write`  in  1  1=write, 0=read
- `reqN_addr`  in  ADDR_W  transaction address
- `reqN_wdata`  in  DATA_W  write data
- `reqN_ack`  out  1  one-cycle pulse: request captured
- `reqN_done`  out  1  one-cycle pulse: transaction complete
- `reqN_rdata`  out  DATA_W  read data, valid with `reqN_done`
- `reqN_err`  out  1  error status, valid with `reqN_done`
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `pwrite`  out  1  APB direction
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `prdata`  in  DATA_W  APB read data
- `pready`  in  1  APB slave ready
- `pslverr`  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: psel=0, penable=0. If any `reqN_valid`=1, arbitrate, capture winner's write/addr/wdata into `pwrite/paddr/pwdata`, go to SETUP.
- SETUP: psel=1, penable=0, winner's `reqN_ack`=1. Always go to ACCESS.
- ACCESS: psel=1, penable=1. Stay while `pready`=0 and watchdog not expired. On completion, register result; next cycle pulse `reqN_done` of the granted requester. If any `reqN_valid`=1 at completion, arbitrate and go directly to SETUP; else IDLE.
- Arbitration: round-robin. `last_grant` register; if both valid, grant the one ≠ `last_grant`; if one valid, grant it. Update `last_grant` on every grant. Reset value `last_grant`=1, so req0 wins the first contention.
- Requester rule: hold `reqN_valid` and fields stable until `reqN_ack`; deassert `reqN_valid` the cycle after ack unless presenting a new transaction. Fields are captured at grant and need not be held afterwards.
- Result: read completes with `reqN_rdata`=`prdata`, `reqN_err`=`pslverr`. Write completes with `reqN_rdata`=0, `reqN_err`=`pslverr`.
- Watchdog: counter clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0. When the count reaches TIMEOUT (TIMEOUT≠0), the transfer completes as if `pready`=1 with `reqN_err`=1, `reqN_rdata`=0, and `prdata`/`pslverr` are ignored.
- `paddr/pwdata/pwrite` hold their last values in IDLE.

## Timing
- Reset (async, immediate): state=IDLE, psel=0, penable=0, paddr=0, pwdata=0, pwrite=0, all `reqN_ack/done/err`=0, `reqN_rdata`=0, watchdog=0, `last_grant`=1. An in-flight transfer is abandoned and no done is issued.
- Zero-wait latency: valid at cycle 0 → SETUP/ack at cycle 1 → ACCESS at cycle 2 (pready=1) → done at cycle 3.
- Each wait-state cycle (`pready`=0) adds one cycle to done latency.
- Back-to-back: the cycle carrying done for transfer A is the SETUP of transfer B. No IDLE gap.
- Watchdog with TIMEOUT=T and `pready` held 0: ACCESS lasts T cycles; done+err asserts on the cycle after the T-th.
- Ack and done are never asserted for both requesters in the same cycle. Done for N and ack for the other requester may coincide.

## Test plan
- Single read, req0 addr=0x10, pready=1 immediately, prdata=0xDEADBEEF → ack0 @1, psel@1–2, penable@2, done0 @3, rdata0=0xDEADBEEF, err0=0.
- Write req1 addr=0x20 wdata=0xA5A5A5A5, pready low 3 cycles → ACCESS 4 cycles, pwdata stable throughout, done1 with rdata1=0, err1=0.
- Both valid from reset, each issuing 4 requests back-to-back → grants alternate 0,1,0,1,…; no IDLE between transfers; each done pairs with the correct requester.
- TIMEOUT=4, pready held 0 → done after 4 ACCESS cycles, err=1, rdata=0, psel/penable drop the next cycle.
- pslverr=1 on a read completion → done with err=1, rdata=prdata.
- Assert reset mid-ACCESS → psel/penable=0 immediately, no done issued; after release, a new req0 completes normally with ack0 1 cycle after valid.
